// File: rtl/pipe_rca_adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor.
// Operation encoding and the operand-split legality check used at elaboration.
package pipe_rca_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic bit slices_even(input int bits, input int stages);
    return (stages >= 1) && (bits >= stages) && ((bits % stages) == 0);
  endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational ripple-carry slice built from a gate-level full-adder chain.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module rca_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co,
  output logic         cm
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    logic c_in;
    logic p;
    logic c_out;

    if (i == 0) begin : g_lsb
      assign c_in = ci;
    end else begin : g_chain
      assign c_in = g_bit[i-1].c_out;
    end

    assign p      = a[i] ^ b[i];
    assign sum[i] = p ^ c_in;
    assign c_out  = (a[i] & b[i]) | (p & c_in);
  end

  assign co = g_bit[W-1].c_out;
  assign cm = g_bit[W-1].c_in;

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one SLICE-wide ripple per stage,
// with valid/ready flow control and bubble-collapsing backpressure.
module pipe_rca_adder
  import pipe_rca_adder_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            ci,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] sum,
  output logic            co,
  output logic            ovf
);

  localparam int SLICE = BITS / STAGES;

  if (!slices_even(BITS, STAGES)) begin : g_bad_split
    $error("pipe_rca_adder: BITS must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][BITS-1:0]  a_q;
  logic [STAGES-1:0][BITS-1:0]  b_q;
  logic [STAGES-1:0][BITS-1:0]  s_q;
  logic                         ovf_q;

  logic [STAGES:0]              rdy;
  logic [STAGES-1:0]            src_v;
  logic [STAGES-1:0]            src_c;
  logic [STAGES-1:0][BITS-1:0]  src_a;
  logic [STAGES-1:0][BITS-1:0]  src_b;
  logic [STAGES-1:0][BITS-1:0]  src_s;
  logic [STAGES-1:0][BITS-1:0]  s_nxt;
  logic [STAGES-1:0][SLICE-1:0] sl_sum;
  logic [STAGES-1:0]            sl_co;
  logic [STAGES-1:0]            sl_cm;

  // A stage can load when it is empty or its successor is taking its content.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
  end

  // Stage 0 sees the effective operands; later stages see the skew registers.
  always_comb begin
    src_v    = '0;
    src_c    = '0;
    src_a    = '0;
    src_b    = '0;
    src_s    = '0;
    src_v[0] = in_valid;
    src_a[0] = a;
    src_b[0] = (sub == OP_SUB) ? ~b : b;
    src_c[0] = ci ^ (sub == OP_SUB);
    for (int k = 1; k < STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_c[k] = c_q[k-1];
      src_s[k] = s_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_slice #(.W(SLICE)) u_slice (
      .a   (src_a[k][k*SLICE +: SLICE]),
      .b   (src_b[k][k*SLICE +: SLICE]),
      .ci  (src_c[k]),
      .sum (sl_sum[k]),
      .co  (sl_co[k]),
      .cm  (sl_cm[k])
    );
  end

  always_comb begin
    s_nxt = src_s;
    for (int k = 0; k < STAGES; k++) begin
      s_nxt[k][k*SLICE +: SLICE] = sl_sum[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (rdy[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k] <= src_a[k];
            b_q[k] <= src_b[k];
            s_q[k] <= s_nxt[k];
            c_q[k] <= sl_co[k];
          end
        end
      end
      if (rdy[STAGES-1] && src_v[STAGES-1]) begin
        ovf_q <= sl_cm[STAGES-1] ^ sl_co[STAGES-1];
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign co        = c_q[STAGES-1];
  assign ovf       = ovf_q;

  // Operand bits outside a stage's own slice are simply forwarded or dropped.
  logic unused_bits;
  assign unused_bits = ^{a_q[STAGES-1], b_q[STAGES-1], src_a, src_b, sl_cm};

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Randomised and directed checks of pipe_rca_adder against an arithmetic model.
// Two instances: 8-bit/2-stage for directed corners, 32-bit/4-stage for flow control.
module tb_pipe_rca_adder;

  localparam int S32 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ovf;
  logic [31:0] a, b, sum;
  logic        in_valid8, in_ready8, ci8, sub8, out_valid8, out_ready8, co8, ovf8;
  logic [7:0]  a8, b8, sum8;

  pipe_rca_adder #(.BITS(32), .STAGES(S32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .co(co), .ovf(ovf)
  );

  pipe_rca_adder #(.BITS(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .ci(ci8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .sum(sum8), .co(co8), .ovf(ovf8)
  );

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  bit   chk_lat = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Unsigned and signed results straight from integer arithmetic.
  function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic s);
    exp_t   r;
    longint m  = longint'(1) << w;
    longint ux = longint'({32'b0, x});
    longint uy = longint'({32'b0, y});
    longint cl = c ? 1 : 0;
    longint t, sx, sy, st;
    if (!s) begin
      t    = ux + uy + cl;
      r.co = (t >= m);
    end else begin
      t    = ux + m - uy - cl;
      r.co = (ux >= uy + cl);
    end
    r.sum = 32'(t % m);
    sx    = (ux >= m / 2) ? ux - m : ux;
    sy    = (uy >= m / 2) ? uy - m : uy;
    st    = s ? (sx - sy - cl) : (sx + sy + cl);
    r.ovf = (st >= m / 2) || (st < -(m / 2));
    r.cyc = 0;
    return r;
  endfunction

  // Called at a falling edge with inputs driven; scores this cycle, then advances one clock.
  task automatic step();
    exp_t e;
    #1;
    if (chk_lat && exp_q.size() > 0 && (cyc - exp_q[0].cyc) == S32)
      check_eq("latency_valid", 64'(out_valid), 64'(1));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_out_valid", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check_eq("sum", 64'(sum), 64'(e.sum));
        check_eq("co", 64'(co), 64'(e.co));
        check_eq("ovf", 64'(ovf), 64'(e.ovf));
        if (chk_lat) check_eq("latency", 64'(cyc - e.cyc), 64'(S32));
      end
    end
    if (in_valid && in_ready) begin
      e     = model(32, a, b, ci, sub);
      e.cyc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic rand_op();
    a   = $urandom;
    b   = $urandom;
    ci  = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 30 && exp_q.size() > 0; i++) step();
    check_eq("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c,
                     input logic s, input string tag);
    exp_t e;
    a8 = x; b8 = y; ci8 = c; sub8 = s; in_valid8 = 1'b1;
    #1;
    check_eq({tag, "_in_ready"}, 64'(in_ready8), 64'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    e = model(8, {24'b0, x}, {24'b0, y}, c, s);
    check_eq({tag, "_valid"}, 64'(out_valid8), 64'(1));
    check_eq({tag, "_sum"}, 64'(sum8), 64'(e.sum[7:0]));
    check_eq({tag, "_co"}, 64'(co8), 64'(e.co));
    check_eq({tag, "_ovf"}, 64'(ovf8), 64'(e.ovf));
  endtask

  initial begin
    logic [31:0] held;
    int          added;
    bit          pat[4];
    bit          tog[4];

    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("rst_sum", 64'(sum), 64'(0));
    check_eq("rst_co", 64'(co), 64'(0));
    check_eq("rst_ovf", 64'(ovf), 64'(0));
    check_eq("rst_in_ready", 64'(in_ready), 64'(1));
    check_eq("rst_out_valid8", 64'(out_valid8), 64'(0));
    @(negedge clk);

    // Directed corners on the 8-bit instance.
    op8(8'hFF, 8'h01, 1'b0, 1'b0, "add_wrap");
    op8(8'h7F, 8'h01, 1'b0, 1'b0, "add_ovf");
    op8(8'h05, 8'h07, 1'b0, 1'b1, "sub_borrow");
    op8(8'h80, 8'h01, 1'b0, 1'b1, "sub_ovf");
    op8(8'h00, 8'h00, 1'b1, 1'b1, "sub_borrow_in");
    op8(8'hFF, 8'hFF, 1'b1, 1'b0, "add_carry_in");
    for (int i = 0; i < 4; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand8");
    @(negedge clk);

    // Back-to-back streaming with the output always accepting.
    chk_lat = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1;
      rand_op();
      if (i % 10 == 0) begin a = '1; b = 32'h1; sub = 1'b0; end
      step();
    end
    drain();
    chk_lat = 1'b0;

    // Full backpressure: exactly STAGES accepts, then a stable held output.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      rand_op();
      step();
    end
    check_eq("bp_accepts", 64'(exp_q.size()), 64'(S32));
    check_eq("bp_in_ready", 64'(in_ready), 64'(0));
    check_eq("bp_out_valid", 64'(out_valid), 64'(1));
    held = sum;
    in_valid = 1'b0;
    repeat (3) step();
    check_eq("bp_hold_sum", 64'(sum), 64'(held));
    check_eq("bp_hold_expected", 64'(sum), 64'(exp_q[0].sum));
    out_ready = 1'b1;
    #1;
    check_eq("bp_reopen", 64'(in_ready), 64'(1));
    tog = '{1'b1, 1'b0, 1'b1, 1'b0};
    foreach (tog[i]) begin
      out_ready = tog[i];
      step();
    end
    check_eq("bp_toggle_left", 64'(exp_q.size()), 64'(S32 - 2));
    drain();

    // Bubbles collapse toward a stalled output.
    out_ready = 1'b0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    foreach (pat[i]) begin
      in_valid = pat[i];
      rand_op();
      step();
    end
    check_eq("bub_count", 64'(exp_q.size()), 64'(2));
    check_eq("bub_out_valid", 64'(out_valid), 64'(1));
    added = 0;
    for (int i = 0; i < 6; i++) begin
      if (!in_ready) break;
      in_valid = 1'b1;
      rand_op();
      step();
      added++;
    end
    check_eq("bub_extra_accepts", 64'(added), 64'(2));
    check_eq("bub_in_ready", 64'(in_ready), 64'(0));
    drain();

    // Asynchronous reset with three operations in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      rand_op();
      step();
    end
    in_valid = 1'b0;
    step();
    check_eq("pre_rst_out_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check_eq("mid_rst_sum", 64'(sum), 64'(0));
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'(1));
    check_eq("post_rst_out_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    out_ready = 1'b1;
    repeat (8) step();
    in_valid = 1'b1;
    rand_op();
    step();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
